// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receive path.
//   rx_state_t    : receiver FSM state encoding
//   ticks_per_bit : user_clk ticks in one bit period
//   half_bit      : ticks from start edge to the middle of the start bit
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic int ticks_per_bit(input int clk_hz, input int baud_hz);
    return clk_hz / baud_hz;
  endfunction

  function automatic int half_bit(input int tpb);
    return tpb >> 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// uart_rx_sync_2ff: two-flop synchroniser for one asynchronous input bit.
//   user_clk : destination clock
//   rst_n    : asynchronous, active-low reset (both flops load RESET_VALUE)
//   d        : asynchronous input
//   q        : synchronised output
module uart_rx_sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic user_clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
//   user_clk      : system clock
//   rst_n         : asynchronous, active-low reset
//   rx_bit        : asynchronous serial line, idles high
//   data          : last correctly framed byte
//   data_valid    : one-cycle strobe, data newly updated
//   framing_error : one-cycle strobe, stop bit sampled low
//   busy          : high while a frame is in progress
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | timing to mid start bit to confirm it is still low
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling the stop bit, then strobe data or framing error
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQUENCY  = 66_000_000,
  parameter int UART_FREQUENCY = 921_600
) (
  input  logic       user_clk,
  input  logic       rst_n,
  input  logic       rx_bit,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int TICKS_PER_BIT = ticks_per_bit(CLK_FREQUENCY, UART_FREQUENCY);
  localparam int HALF_BIT      = half_bit(TICKS_PER_BIT);
  localparam logic [11:0] BIT_LAST  = 12'(TICKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(HALF_BIT - 1);

  rx_state_t   state, state_nxt;
  logic        rx_s, rx_d;
  logic [11:0] clk_count;
  logic [2:0]  bit_count;
  logic [7:0]  shift_reg;
  logic        start_edge, half_done, bit_done;

  uart_rx_sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .user_clk (user_clk),
    .rst_n    (rst_n),
    .d        (rx_bit),
    .q        (rx_s)
  );

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) rx_d <= 1'b1;
    else        rx_d <= rx_s;
  end

  // Edge, not level: a line held low after a break cannot start a new frame.
  assign start_edge = rx_d & ~rx_s;
  assign half_done  = (clk_count == HALF_LAST);
  assign bit_done   = (clk_count == BIT_LAST);
  assign busy       = (state != IDLE);

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (half_done) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_done && bit_count == 3'd7) state_nxt = STOP;
      // Leaving mid stop bit lets a start edge right after the stop bit be seen.
      STOP:    if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_count     <= '0;
      bit_count     <= '0;
      shift_reg     <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        START: begin
          if (half_done) clk_count <= '0;
          else           clk_count <= clk_count + 12'd1;
        end
        DATA: begin
          if (bit_done) begin
            clk_count <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_count <= bit_count + 3'd1;
          end else begin
            clk_count <= clk_count + 12'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            clk_count <= '0;
            if (rx_s) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            clk_count <= clk_count + 12'd1;
          end
        end
        default: begin
          clk_count <= '0;
          bit_count <= '0;
        end
      endcase
    end
  end

endmodule
